match_finder_block_splitter: RTL and testbench



---
 rtl/match_finder_pkg.sv | 50 +++++
 rtl/match_finder_block_splitter_req_builder.sv | 30 +++
 rtl/match_finder_block_splitter.sv | 212 +++++++++++++++++++++
 tb/tb_match_finder_block_splitter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_finder_pkg.sv
// Shared types for the match-finder front end: bus layouts, status codes and FSM states.
// Each packed struct lists its fields MSB first, so the struct layout fixes every field offset.
package match_finder_pkg;

    localparam int unsigned DEFAULT_BLOCK_SIZE = 131072;

    localparam int ADDR_FIELD_W = 32;
    localparam int PARAMS_W     = 10;
    localparam int STATUS_W     = 2;
    localparam int RESV_W       = 72;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK       = 2'd0,
        ST_AXI_ERR  = 2'd1,
        ST_OVERFLOW = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    // The frame request and the per-block request share this layout.
    typedef struct packed {
        logic [ADDR_FIELD_W-1:0] in_addr;
        logic [ADDR_FIELD_W-1:0] in_size;
        logic [ADDR_FIELD_W-1:0] lit_addr;
        logic [ADDR_FIELD_W-1:0] seq_addr;
        logic [PARAMS_W-1:0]     params;
    } frame_req_t;

    typedef struct packed {
        logic [STATUS_W-1:0]     status;
        logic [ADDR_FIELD_W-1:0] lit_cnt;
        logic [ADDR_FIELD_W-1:0] seq_cnt;
        logic [RESV_W-1:0]       reserved;
    } mf_resp_t;

    typedef struct packed {
        logic [STATUS_W-1:0]     status;
        logic [ADDR_FIELD_W-1:0] lit_total;
        logic [ADDR_FIELD_W-1:0] seq_total;
        logic [ADDR_FIELD_W-1:0] blk_cnt;
    } frame_resp_t;

    localparam int FRAME_RESP_W = $bits(frame_resp_t);

endpackage

// File: rtl/match_finder_block_splitter_req_builder.sv
// Combinational block sizing and payload packing for one match-finder block request.
module mf_req_builder
    import match_finder_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
    input  logic [ADDR_W-1:0]   in_addr_i,
    input  logic [ADDR_W-1:0]   remaining_i,
    input  logic [ADDR_W-1:0]   lit_addr_i,
    input  logic [ADDR_W-1:0]   seq_addr_i,
    input  logic [PARAMS_W-1:0] params_i,
    output logic [ADDR_W-1:0]   blk_size_o,
    output frame_req_t          req_o
);

    localparam logic [ADDR_W-1:0] BLK_MAX = ADDR_W'(BLOCK_SIZE);

    always_comb begin
        blk_size_o = (remaining_i > BLK_MAX) ? BLK_MAX : remaining_i;
        req_o = '{
            in_addr:  in_addr_i,
            in_size:  blk_size_o,
            lit_addr: lit_addr_i,
            seq_addr: seq_addr_i,
            params:   params_i
        };
    end

endmodule

// File: rtl/match_finder_block_splitter.sv
// Splits one frame request into BLOCK_SIZE chunks, issues them one at a time to the
// match finder, and folds the per-block responses into a single frame response.
module match_finder_block_splitter
    import match_finder_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter int unsigned SEQ_BYTES  = 8,
    parameter int          MF_REQ_W   = 138,
    parameter int          MF_RESP_W  = 138
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MF_REQ_W-1:0]     frame_req_data,
    input  logic                    frame_req_vld,
    output logic                    frame_req_rdy,
    output logic [MF_REQ_W-1:0]     mf_req_data,
    output logic                    mf_req_vld,
    input  logic                    mf_req_rdy,
    input  logic [MF_RESP_W-1:0]    mf_resp_data,
    input  logic                    mf_resp_vld,
    output logic                    mf_resp_rdy,
    output logic [FRAME_RESP_W-1:0] frame_resp_data,
    output logic                    frame_resp_vld,
    input  logic                    frame_resp_rdy
);

    localparam bit SEQ_POW2 = (SEQ_BYTES & (SEQ_BYTES - 1)) == 0;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   in_addr_q, in_addr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]   lit_addr_q, lit_addr_d;
    logic [ADDR_W-1:0]   seq_addr_q, seq_addr_d;
    logic [ADDR_W-1:0]   lit_total_q, lit_total_d;
    logic [ADDR_W-1:0]   seq_total_q, seq_total_d;
    logic [ADDR_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [PARAMS_W-1:0] params_q, params_d;
    logic [STATUS_W-1:0] status_q, status_d;

    frame_req_t        fr_req;
    frame_req_t        blk_req;
    mf_resp_t          mf_resp;
    frame_resp_t       fr_resp;
    logic [ADDR_W-1:0] blk_size;
    logic [RESV_W-1:0] unused_resv;

    assign fr_req      = frame_req_data;
    assign mf_resp     = mf_resp_data;
    assign unused_resv = mf_resp.reserved;

    mf_req_builder #(
        .ADDR_W     (ADDR_W),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_req_builder (
        .in_addr_i   (in_addr_q),
        .remaining_i (remaining_q),
        .lit_addr_i  (lit_addr_q),
        .seq_addr_i  (seq_addr_q),
        .params_i    (params_q),
        .blk_size_o  (blk_size),
        .req_o       (blk_req)
    );

    // Response "apply" point: same cycle as the handshake for a shift, one cycle later for a multiply.
    logic                resp_fire, resp_pend, apply;
    logic [STATUS_W-1:0] a_status;
    logic [ADDR_W-1:0]   a_lit, a_seq, a_seq_bytes;

    assign resp_fire = mf_resp_vld && mf_resp_rdy;

    generate
        if (SEQ_POW2) begin : g_shift
            localparam int SH = $clog2(SEQ_BYTES);
            assign resp_pend   = 1'b0;
            assign apply       = resp_fire;
            assign a_status    = mf_resp.status;
            assign a_lit       = mf_resp.lit_cnt;
            assign a_seq       = mf_resp.seq_cnt;
            assign a_seq_bytes = mf_resp.seq_cnt << SH;
        end else begin : g_mul
            logic                pend_q;
            logic [STATUS_W-1:0] st_q;
            logic [ADDR_W-1:0]   lit_q, seq_q, prod_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_q <= 1'b0;
                    st_q   <= '0;
                    lit_q  <= '0;
                    seq_q  <= '0;
                    prod_q <= '0;
                end else begin
                    pend_q <= resp_fire;
                    if (resp_fire) begin
                        st_q   <= mf_resp.status;
                        lit_q  <= mf_resp.lit_cnt;
                        seq_q  <= mf_resp.seq_cnt;
                        prod_q <= mf_resp.seq_cnt * ADDR_W'(SEQ_BYTES);
                    end
                end
            end
            assign resp_pend   = pend_q;
            assign apply       = pend_q;
            assign a_status    = st_q;
            assign a_lit       = lit_q;
            assign a_seq       = seq_q;
            assign a_seq_bytes = prod_q;
        end
    endgenerate

    // Handshake outputs decode from state only; frame_req_rdy is also masked while reset is held.
    assign frame_req_rdy  = (state_q == S_IDLE) && !rst;
    assign mf_req_vld     = (state_q == S_ISSUE);
    assign mf_resp_rdy    = (state_q == S_WAIT) && !resp_pend;
    assign frame_resp_vld = (state_q == S_RESP);
    assign mf_req_data    = blk_req;

    assign fr_resp = '{
        status:    status_q,
        lit_total: lit_total_q,
        seq_total: seq_total_q,
        blk_cnt:   blk_cnt_q
    };
    assign frame_resp_data = fr_resp;

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
        state_d     = state_q;
        in_addr_d   = in_addr_q;
        remaining_d = remaining_q;
        lit_addr_d  = lit_addr_q;
        seq_addr_d  = seq_addr_q;
        lit_total_d = lit_total_q;
        seq_total_d = seq_total_q;
        blk_cnt_d   = blk_cnt_q;
        params_d    = params_q;
        status_d    = status_q;

        unique case (state_q)
            S_IDLE: begin
                if (frame_req_vld) begin
                    in_addr_d   = fr_req.in_addr;
                    remaining_d = fr_req.in_size;
                    lit_addr_d  = fr_req.lit_addr;
                    seq_addr_d  = fr_req.seq_addr;
                    params_d    = fr_req.params;
                    lit_total_d = '0;
                    seq_total_d = '0;
                    blk_cnt_d   = '0;
                    status_d    = ST_OK;
                    state_d     = (fr_req.in_size == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mf_req_rdy) begin
                    in_addr_d   = in_addr_q + blk_size;
                    remaining_d = remaining_q - blk_size;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (apply) begin
                    lit_addr_d  = lit_addr_q + a_lit;
                    seq_addr_d  = seq_addr_q + a_seq_bytes;
                    lit_total_d = lit_total_q + a_lit;
                    seq_total_d = seq_total_q + a_seq;
                    blk_cnt_d   = blk_cnt_q + 1'b1;
                    if (a_status != ST_OK) begin
                        status_d = a_status;
                        state_d  = S_RESP;
                    end else if (remaining_q == '0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_RESP: begin
                if (frame_resp_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_addr_q   <= '0;
            remaining_q <= '0;
            lit_addr_q  <= '0;
            seq_addr_q  <= '0;
            lit_total_q <= '0;
            seq_total_q <= '0;
            blk_cnt_q   <= '0;
            params_q    <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_addr_q   <= in_addr_d;
            remaining_q <= remaining_d;
            lit_addr_q  <= lit_addr_d;
            seq_addr_q  <= seq_addr_d;
            lit_total_q <= lit_total_d;
            seq_total_q <= seq_total_d;
            blk_cnt_q   <= blk_cnt_d;
            params_q    <= params_d;
            status_q    <= status_d;
        end
    end

endmodule

// File: tb/tb_match_finder_block_splitter.sv
// Scoreboard bench: a frame-level model queues expected block requests and frame responses.
module tb_match_finder_block_splitter;

    localparam logic [31:0] BS    = 32'd131072;
    localparam logic [31:0] SEQ_B = 32'd8;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] lit;
        logic [31:0] seq;
    } plan_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [137:0] frame_req_data;
    logic         frame_req_vld;
    logic         frame_req_rdy;
    logic [137:0] mf_req_data;
    logic         mf_req_vld;
    logic         mf_req_rdy;
    logic [137:0] mf_resp_data;
    logic         mf_resp_vld;
    logic         mf_resp_rdy;
    logic [97:0]  frame_resp_data;
    logic         frame_resp_vld;
    logic         frame_resp_rdy;

    int vectors     = 0;
    int miscompares = 0;

    logic [137:0] exp_req_q[$];
    logic [97:0]  exp_frame_q[$];
    plan_t        plan_q[$];
    plan_t        drv_q[$];

    always #5 clk = ~clk;

    match_finder_block_splitter dut (
        .clk             (clk),
        .rst             (rst),
        .frame_req_data  (frame_req_data),
        .frame_req_vld   (frame_req_vld),
        .frame_req_rdy   (frame_req_rdy),
        .mf_req_data     (mf_req_data),
        .mf_req_vld      (mf_req_vld),
        .mf_req_rdy      (mf_req_rdy),
        .mf_resp_data    (mf_resp_data),
        .mf_resp_vld     (mf_resp_vld),
        .mf_resp_rdy     (mf_resp_rdy),
        .frame_resp_data (frame_resp_data),
        .frame_resp_vld  (frame_resp_vld),
        .frame_resp_rdy  (frame_resp_rdy)
    );

    // Frame model: consumes plan_q (one response per block) and fills the scoreboard queues.
    task automatic build_expect(input logic [31:0] a, input logic [31:0] sz, input logic [31:0] la,
                                input logic [31:0] sa, input logic [9:0] pr);
        logic [31:0] rem, blk, lt, stt, bc;
        logic [1:0]  status;
        plan_t       r;
        int          k;
        rem = sz; lt = '0; stt = '0; bc = '0; status = 2'd0; k = 0;
        while (rem != 0 && k < plan_q.size()) begin
            blk = (rem > BS) ? BS : rem;
            exp_req_q.push_back({a, blk, la, sa, pr});
            r = plan_q[k];
            k++;
            a   = a + blk;
            rem = rem - blk;
            la  = la + r.lit;
            sa  = sa + r.seq * SEQ_B;
            lt  = lt + r.lit;
            stt = stt + r.seq;
            bc  = bc + 32'd1;
            if (r.st != 2'd0) begin
                status = r.st;
                break;
            end
        end
        exp_frame_q.push_back({status, lt, stt, bc});
        drv_q = plan_q;
        plan_q.delete();
    endtask

    task automatic run_frame(input logic [31:0] a, input logic [31:0] sz, input logic [31:0] la,
                             input logic [31:0] sa, input logic [9:0] pr,
                             input int req_stall, input int resp_stall);
        logic [137:0] er;
        logic [97:0]  ef;
        plan_t        r;
        int           n;
        bit           done;
        bit           unexp;
        build_expect(a, sz, la, sa, pr);
        @(negedge clk);
        frame_req_data = {a, sz, la, sa, pr};
        frame_req_vld  = 1'b1;
        n = 0;
        while (!frame_req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (frame_req_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_req_rdy wait: got %b required 1", frame_req_rdy);
        end
        @(negedge clk);
        frame_req_vld = 1'b0;
        vectors++;
        if ({mf_req_vld, frame_resp_vld} !== {sz != 0, sz == 0}) begin
            miscompares++;
            $display("FAIL frame latency: mf_req_vld/frame_resp_vld got %b%b required %b%b",
                     mf_req_vld, frame_resp_vld, sz != 0, sz == 0);
        end

        done = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            n++;
            if (mf_req_vld === 1'b1) begin
                unexp = (exp_req_q.size() == 0);
                er = '0;
                if (unexp) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected mf_req: got %h required none", mf_req_data);
                end else begin
                    er = exp_req_q.pop_front();
                end
                for (int s = 0; s < req_stall; s++) begin
                    mf_resp_data = {2'd3, 32'hdead_0000, 32'h0000_beef, 72'h0};
                    mf_resp_vld  = 1'b1;
                    @(negedge clk);
                    if (!unexp) begin
                        vectors++;
                        if ({mf_req_vld, mf_resp_rdy, mf_req_data} !== {1'b1, 1'b0, er}) begin
                            miscompares++;
                            $display("FAIL mf_req hold: vld=%b resp_rdy=%b data=%h required 1 0 %h",
                                     mf_req_vld, mf_resp_rdy, mf_req_data, er);
                        end
                    end
                end
                mf_resp_vld = 1'b0;
                if (!unexp) begin
                    vectors++;
                    if (mf_req_data !== er) begin
                        miscompares++;
                        $display("FAIL mf_req payload: got %h required %h", mf_req_data, er);
                    end
                end
                mf_req_rdy = 1'b1;
                @(negedge clk);
                mf_req_rdy = 1'b0;
                vectors++;
                if ({mf_resp_rdy, mf_req_vld} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL wait entry: resp_rdy/req_vld got %b%b required 10", mf_resp_rdy, mf_req_vld);
                end
                r = (drv_q.size() != 0) ? drv_q.pop_front() : '0;
                mf_resp_data = {r.st, r.lit, r.seq, 72'h0};
                mf_resp_vld  = 1'b1;
                @(negedge clk);
                mf_resp_vld = 1'b0;
                vectors++;
                if ({mf_resp_rdy, (mf_req_vld | frame_resp_vld)} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL resp turnaround: resp_rdy=%b next_vld=%b required 0 1",
                             mf_resp_rdy, mf_req_vld | frame_resp_vld);
                end
            end else if (frame_resp_vld === 1'b1) begin
                unexp = (exp_frame_q.size() == 0);
                ef = '0;
                if (unexp) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected frame_resp: got %h required none", frame_resp_data);
                end else begin
                    ef = exp_frame_q.pop_front();
                    vectors++;
                    if (frame_resp_data !== ef) begin
                        miscompares++;
                        $display("FAIL frame_resp payload: got %h required %h", frame_resp_data, ef);
                    end
                end
                for (int s = 0; s < resp_stall; s++) begin
                    @(negedge clk);
                    if (!unexp) begin
                        vectors++;
                        if ({frame_resp_vld, frame_resp_data} !== {1'b1, ef}) begin
                            miscompares++;
                            $display("FAIL frame_resp hold: vld=%b data=%h required 1 %h",
                                     frame_resp_vld, frame_resp_data, ef);
                        end
                    end
                end
                frame_resp_rdy = 1'b1;
                @(negedge clk);
                frame_resp_rdy = 1'b0;
                vectors++;
                if ({frame_resp_vld, frame_req_rdy, mf_req_vld} !== 3'b010) begin
                    miscompares++;
                    $display("FAIL return to idle: resp_vld/req_rdy/mf_req_vld got %b%b%b required 010",
                             frame_resp_vld, frame_req_rdy, mf_req_vld);
                end
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL frame timeout: no frame_resp within %0d cycles, required one", n);
        end
        vectors++;
        if (exp_req_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing mf_req: %0d outstanding, required 0", exp_req_q.size());
        end
        exp_req_q.delete();
        exp_frame_q.delete();
        drv_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if ({frame_req_rdy, mf_req_vld, mf_resp_rdy, frame_resp_vld, mf_req_data, frame_resp_data} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: rdy=%b req_vld=%b resp_rdy=%b fr_vld=%b req=%h fr=%h required all 0",
                     frame_req_rdy, mf_req_vld, mf_resp_rdy, frame_resp_vld, mf_req_data, frame_resp_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (frame_req_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset release rdy: got %b required 1", frame_req_rdy);
        end
    endtask

    task automatic test_zero_size();
        run_frame(32'h4000_0000, 32'd0, 32'h1000, 32'h2000, 10'h155, 0, 0);
    endtask

    task automatic test_single_block();
        plan_q.push_back('{st: 2'd0, lit: 32'd40, seq: 32'd5});
        run_frame(32'h0000_8000, 32'd100, 32'h1000, 32'h2000, 10'h2a3, 0, 0);
    endtask

    task automatic test_block_boundary();
        plan_q.push_back('{st: 2'd0, lit: 32'd7, seq: 32'd9});
        run_frame(32'h0010_0000, BS, 32'h3000, 32'h4000, 10'h001, 0, 0);
        plan_q.push_back('{st: 2'd0, lit: 32'd1, seq: 32'd2});
        plan_q.push_back('{st: 2'd0, lit: 32'd3, seq: 32'd4});
        run_frame(32'h0020_0000, BS + 32'd1, 32'h3000, 32'h4000, 10'h002, 0, 0);
    endtask

    task automatic test_multi_block();
        plan_q.push_back('{st: 2'd0, lit: 32'd10, seq: 32'd3});
        plan_q.push_back('{st: 2'd0, lit: 32'd20, seq: 32'd4});
        plan_q.push_back('{st: 2'd0, lit: 32'd30, seq: 32'd5});
        run_frame(32'h1000_0000, 32'd300000, 32'h5000_0000, 32'h6000_0000, 10'h3ff, 0, 0);
    endtask

    task automatic test_error_abort();
        plan_q.push_back('{st: 2'd0, lit: 32'd11, seq: 32'd2});
        plan_q.push_back('{st: 2'd1, lit: 32'd6,  seq: 32'd1});
        run_frame(32'h2000_0000, 32'd300000, 32'h0, 32'h100, 10'h0f0, 0, 0);
    endtask

    task automatic test_backpressure();
        plan_q.push_back('{st: 2'd0, lit: 32'd100, seq: 32'd12});
        plan_q.push_back('{st: 2'd0, lit: 32'd50,  seq: 32'd6});
        run_frame(32'h3000_0000, 32'd200000, 32'h7000, 32'h8000, 10'h111, 5, 4);
    endtask

    task automatic test_wrap();
        plan_q.push_back('{st: 2'd0, lit: 32'h20, seq: 32'd2});
        plan_q.push_back('{st: 2'd0, lit: 32'd1,  seq: 32'd1});
        run_frame(32'hFFFF_0000, BS + 32'd16, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 10'h2aa, 0, 0);
    endtask

    task automatic test_back_to_back();
        plan_q.push_back('{st: 2'd0, lit: 32'd3, seq: 32'd1});
        run_frame(32'h0000_0100, 32'd64, 32'h10, 32'h20, 10'h004, 0, 0);
        run_frame(32'h0000_0200, 32'd0, 32'h30, 32'h40, 10'h005, 0, 0);
        plan_q.push_back('{st: 2'd2, lit: 32'd9, seq: 32'd8});
        run_frame(32'h0000_0300, 32'd500, 32'h50, 32'h60, 10'h006, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        int n;
        @(negedge clk);
        frame_req_data = {32'h0000_0100, 32'd1000, 32'h0, 32'h0, 10'h0};
        frame_req_vld  = 1'b1;
        n = 0;
        while (!frame_req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        frame_req_vld = 1'b0;
        n = 0;
        while (!mf_req_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        mf_req_rdy = 1'b1;
        @(negedge clk);
        mf_req_rdy = 1'b0;
        vectors++;
        if (mf_resp_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre-reset wait: mf_resp_rdy got %b required 1", mf_resp_rdy);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({frame_req_rdy, mf_req_vld, mf_resp_rdy, frame_resp_vld, mf_req_data, frame_resp_data} !== '0) begin
            miscompares++;
            $display("FAIL async reset: rdy=%b req_vld=%b resp_rdy=%b fr_vld=%b req=%h fr=%h required all 0",
                     frame_req_rdy, mf_req_vld, mf_resp_rdy, frame_resp_vld, mf_req_data, frame_resp_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({frame_req_rdy, mf_req_vld, mf_resp_rdy} !== 3'b100) begin
            miscompares++;
            $display("FAIL post-reset idle: rdy/req_vld/resp_rdy got %b%b%b required 100",
                     frame_req_rdy, mf_req_vld, mf_resp_rdy);
        end
        plan_q.push_back('{st: 2'd0, lit: 32'd17, seq: 32'd3});
        run_frame(32'h0000_0400, 32'd256, 32'h900, 32'hA00, 10'h00f, 0, 0);
    endtask

    initial begin
        rst            = 1'b1;
        frame_req_data = '0;
        frame_req_vld  = 1'b0;
        mf_req_rdy     = 1'b0;
        mf_resp_data   = '0;
        mf_resp_vld    = 1'b0;
        frame_resp_rdy = 1'b0;
        test_reset();
        test_zero_size();
        test_single_block();
        test_block_boundary();
        test_multi_block();
        test_error_abort();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
